// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, block type and ciphertext FIFO sizing.
package aes_pkg;
  localparam int BLOCK_W       = 128;
  localparam int CT_FIFO_DEPTH = 16;
  localparam int CT_FIFO_SKID  = 2;

  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/aes_ct_buffer.sv
// Show-ahead ciphertext FIFO between the encrypt engine and the host, with
// early halt backpressure and counting of blocks dropped when full.
module aes_ct_buffer
  import aes_pkg::*;
#(
  parameter int DEPTH = CT_FIFO_DEPTH,
  parameter int SKID  = CT_FIFO_SKID
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  block_t                   in_data,
  input  logic                     in_valid,
  output logic                     halt,
  input  logic                     flush,
  output block_t                   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  block_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            full, push, pop, drop;

  always_comb begin
    full = (count_q == CW'(DEPTH));
    pop  = (count_q != '0) && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately left out of reset and flush; only pointers matter.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign halt      = (count_q >= CW'(DEPTH - SKID));
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_aes_ct_buffer.sv
// Randomized and directed checks of aes_ct_buffer against a queue-based
// model of the buffer's occupancy, order, overflow and drop counting.
module tb_aes_ct_buffer;
  import aes_pkg::*;

  localparam int DEPTH = 16;
  localparam int SKID  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  block_t      in_data = '0;
  logic        in_valid = 1'b0;
  logic        halt;
  logic        flush = 1'b0;
  block_t      out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  block_t model_q[$];
  bit     model_ovf = 1'b0;
  int     model_drops = 0;

  aes_ct_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .halt(halt), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the model's current state.
  task automatic checkAll();
    int n;
    n = model_q.size();
    checkOutput("count", 128'(count), 128'(n));
    checkOutput("out_valid", 128'(out_valid), 128'(n != 0));
    checkOutput("halt", 128'(halt), 128'(n >= DEPTH - SKID));
    checkOutput("overflow", 128'(overflow), 128'(model_ovf));
    checkOutput("drop_cnt", 128'(drop_cnt), 128'(model_drops));
    if (n != 0) checkOutput("out_data", out_data, model_q[0]);
  endtask

  // Drive one cycle: set inputs, check current state, advance model, clock.
  task automatic applyStimulus(input bit v, input block_t d, input bit r,
                               input bit f);
    bit do_pop, do_push;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
    checkAll();
    do_pop  = (model_q.size() != 0) && r;
    do_push = v && (model_q.size() < DEPTH || do_pop);
    if (f) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_drops = 0;
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
      if (v && !do_push) begin
        model_ovf = 1'b1;
        if (model_drops < 255) model_drops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("rst_count", 128'(count), 128'(0));
    checkOutput("rst_halt", 128'(halt), 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_overflow", 128'(overflow), 128'(0));
    checkOutput("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    model_q.delete();
    model_ovf = 1'b0;
    model_drops = 0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic block_t rndBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    doReset();

    // Single block straight through with host ready.
    applyStimulus(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Fill to full with host stalled, crossing the halt threshold.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, rndBlock(), 1'b0, 1'b0);
    // Drops while full, enough to saturate the drop counter.
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, rndBlock(), 1'b0, 1'b0);
    // Full with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, rndBlock(), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Flush at count 7 while also offering a block.
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, rndBlock(), 1'b0, 1'b0);
    applyStimulus(1'b1, rndBlock(), 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset at count 9, then an immediate first push.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, rndBlock(), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, rndBlock(), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Random traffic in phases of varying producer/consumer pressure.
    for (int phase = 0; phase < 8; phase++) begin
      int pv, pr;
      pv = 20 + 10 * phase;
      pr = 90 - 10 * phase;
      for (int i = 0; i < 250; i++)
        applyStimulus($urandom_range(0, 99) < pv, rndBlock(),
                      $urandom_range(0, 99) < pr,
                      $urandom_range(0, 199) == 0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_ct_buffer.md
AES_CT_BUFFER -- requirements
Module: aes_ct_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: ciphertext FIFO entries (power of two, at least 4).
REQ-002 SHALL have parameter SKID, default 2: free entries reserved before halt is raised (1 to DEPTH-1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  128  ciphertext block from the encrypt engine out port.
REQ-006 in_valid  input  1  engine out_valid; a block is offered this cycle.
REQ-007 halt  output  1  backpressure to the engine halt input.
REQ-008 flush  input  1  synchronous clear of buffer contents.
REQ-009 out_data  output  128  head-of-FIFO ciphertext to the host.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  host accepts out_data.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky: at least one block was dropped.
REQ-014 drop_cnt  output  8  number of dropped blocks, saturating.

Function
REQ-015 Push SHALL occur when in_valid=1 and (count<DEPTH or pop in the same cycle); in_data is written at wr_ptr.
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1; rd_ptr advances.
REQ-017 out_data SHALL be mem[rd_ptr] (show-ahead), with zero added latency after the write edge.
REQ-018 out_valid SHALL equal (count!=0).
REQ-019 A block written at edge N SHALL appear on out_data with out_valid=1 after edge N if the FIFO was empty.
REQ-020 count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 Simultaneous push and pop at count=DEPTH SHALL be accepted; count stays DEPTH.
REQ-022 Simultaneous push and pop at count=0 is impossible (out_valid=0); the push alone SHALL occur.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 halt SHALL be 1 iff count >= DEPTH-SKID; it is decoded from registered count only (no in_valid or out_ready path).
REQ-025 in_valid=1 with count=DEPTH and no pop SHALL drop the block: memory is unchanged, overflow sets to 1, and drop_cnt increments, saturating at 255.
REQ-026 in_valid during halt is legal (engine drain/skid) and SHALL be accepted while space remains.
REQ-027 flush=1 SHALL, at the next edge, zero pointers, count, overflow and drop_cnt, ignoring push and pop that cycle.
REQ-028 Memory contents SHALL not be cleared by reset or flush; out_data is don't-care while out_valid=0.
REQ-029 Block order SHALL be preserved exactly (FIFO); no data transformation.

Reset
REQ-030 While rstn=0: count=0, out_valid=0, halt=0, overflow=0, drop_cnt=0, pointers=0.
REQ-031 Reset assertion mid-operation SHALL discard all buffered blocks immediately, without waiting for a clock.
REQ-032 The first push SHALL be possible on the first rising edge after rstn deasserts.

Structure
REQ-033 BLOCK_W=128 and the block data typedef SHALL come from the shared aes_pkg, also used by encrypt_engine.
REQ-034 DEPTH and SKID defaults SHALL be aes_pkg constants CT_FIFO_DEPTH and CT_FIFO_SKID.
REQ-035 Storage, pointers and control SHALL be implemented inline; no sub-module is required.

Verification
REQ-036 Reset, then push 00112233445566778899aabbccddeeff with out_ready=1 -> out_valid=1 next cycle with that data, then count returns to 0.
REQ-037 out_ready=0, push 14 blocks -> halt=0 at count 13 and halt=1 at count 14; push 2 more -> count=16, overflow=0.
REQ-038 Full FIFO, out_ready=0, push 1 more -> overflow=1, drop_cnt=1, FIFO contents unchanged; 300 drops -> drop_cnt=255.
REQ-039 Full FIFO, in_valid=1 and out_ready=1 for 20 cycles -> count stays 16, and output order matches input order across pointer wrap.
REQ-040 Count 7 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, overflow=0.
REQ-041 rstn pulled low between edges at count 9 -> count=0, halt=0, out_valid=0 before the next edge.
